// File: rtl/hemaia_clock_divisor_monitor_if.sv
// Bundle between a clock-divisor monitor (slave) and the status/config side (master).
`timescale 1ns/1ps
interface hemaia_clock_divisor_monitor_if #(
  parameter int unsigned MaxDivisionWidth = 4
) ();
  logic                        enable_i;
  logic                        clk_div_i;
  logic [MaxDivisionWidth-1:0] expected_divisor_i;
  logic [MaxDivisionWidth-1:0] measured_divisor_o;
  logic                        valid_o;
  logic                        mismatch_o;
  logic                        change_o;
  logic                        range_err_o;
  logic                        stuck_o;
  logic                        stuck_level_o;

  modport master (
    output enable_i, clk_div_i, expected_divisor_i,
    input  measured_divisor_o, valid_o, mismatch_o, change_o,
           range_err_o, stuck_o, stuck_level_o
  );

  modport slave (
    input  enable_i, clk_div_i, expected_divisor_i,
    output measured_divisor_o, valid_o, mismatch_o, change_o,
           range_err_o, stuck_o, stuck_level_o
  );
endinterface

// File: rtl/hemaia_clock_divisor_monitor.sv
// Recovers the effective divisor of a divided clock by timing its rising edges in
// source-clock cycles; reports lock, change, out-of-range and stuck/gated status.
//   state    | meaning
//   IDLE     | disabled, period counter held at 0
//   ACQUIRE  | waiting for first edge; partial first period is discarded
//   MEASURE  | collecting identical periods toward lock
//   LOCKED   | measured divisor valid and being re-confirmed every period
//   STUCK    | no edge within the timeout (gated, bypassed or dead)
`timescale 1ns/1ps
module hemaia_clock_divisor_monitor #(
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned MatchCount       = 4,
  parameter int unsigned TimeoutCycles    = 2**(MaxDivisionWidth+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  hemaia_clock_divisor_monitor_if.slave mon
);

  localparam int unsigned CntWidth   = MaxDivisionWidth + 2;
  localparam int unsigned MatchWidth = $clog2(MatchCount + 1);

  localparam logic [CntWidth-1:0]   MaxPeriod  = CntWidth'((2**MaxDivisionWidth) - 1);
  localparam logic [CntWidth-1:0]   TimeoutVal = CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0]   CntOne     = CntWidth'(1);
  localparam logic [MatchWidth-1:0] MatchOne   = MatchWidth'(1);
  localparam logic [MatchWidth-1:0] LockAt     = MatchWidth'(MatchCount - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAcquire = 3'd1;
  localparam logic [2:0] StMeasure = 3'd2;
  localparam logic [2:0] StLocked  = 3'd3;
  localparam logic [2:0] StStuck   = 3'd4;

  logic [SyncStages-1:0]       sync_q;
  logic                        prev_q;
  logic [2:0]                  state_q, state_d;
  logic [CntWidth-1:0]         cnt_q, cnt_d;
  logic [MatchWidth-1:0]       match_q, match_d;
  logic [MaxDivisionWidth-1:0] cand_q, cand_d;
  logic [MaxDivisionWidth-1:0] meas_q, meas_d;
  logic                        valid_q, valid_d;
  logic                        stuck_q, stuck_d;
  logic                        change_q, change_d;
  logic                        range_q, range_d;

  logic                        sync_level;
  logic                        rise;
  logic [CntWidth-1:0]         cnt_inc;
  logic [MaxDivisionWidth-1:0] period;
  logic                        in_range;
  logic                        timeout;
  logic                        same_cand;
  logic                        lock_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], mon.clk_div_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign sync_level = sync_q[SyncStages-1];
  assign rise       = sync_level & ~prev_q;
  // Saturate so a long gap never wraps back into the legal period range.
  assign cnt_inc    = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntOne;
  assign period     = cnt_q[MaxDivisionWidth-1:0];
  assign in_range   = (cnt_q <= MaxPeriod);
  assign timeout    = (cnt_q >= TimeoutVal);
  assign same_cand  = (period == cand_q);
  assign lock_hit   = same_cand ? (match_q >= LockAt) : (MatchCount == 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    match_d  = match_q;
    cand_d   = cand_q;
    meas_d   = meas_q;
    valid_d  = valid_q;
    stuck_d  = stuck_q;
    change_d = 1'b0;
    range_d  = 1'b0;
    if (!mon.enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
      stuck_d = 1'b0;
    end else begin
      if (rise) cnt_d = CntOne;
      case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StAcquire;
        end
        StAcquire: begin
          if (rise) begin
            match_d = '0;
            state_d = StMeasure;
          end else if (timeout) begin
            stuck_d = 1'b1;
            state_d = StStuck;
          end
        end
        StMeasure: begin
          if (rise) begin
            if (!in_range) begin
              range_d = 1'b1;
              match_d = '0;
            end else begin
              cand_d  = period;
              match_d = same_cand ? match_q + MatchOne : MatchOne;
              if (lock_hit) begin
                meas_d  = period;
                valid_d = 1'b1;
                state_d = StLocked;
              end
            end
          end else if (timeout) begin
            stuck_d = 1'b1;
            state_d = StStuck;
          end
        end
        StLocked: begin
          if (rise) begin
            if (cnt_q != CntWidth'(meas_q)) begin
              change_d = 1'b1;
              valid_d  = 1'b0;
              state_d  = StMeasure;
              if (in_range) begin
                cand_d  = period;
                match_d = MatchOne;
              end else begin
                range_d = 1'b1;
                match_d = '0;
              end
            end
          end else if (timeout) begin
            valid_d = 1'b0;
            stuck_d = 1'b1;
            state_d = StStuck;
          end
        end
        StStuck: begin
          if (rise) begin
            match_d = '0;
            stuck_d = 1'b0;
            state_d = StMeasure;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      match_q  <= '0;
      cand_q   <= '0;
      meas_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      change_q <= 1'b0;
      range_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      meas_q   <= meas_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      change_q <= change_d;
      range_q  <= range_d;
    end
  end

  assign mon.measured_divisor_o = meas_q;
  assign mon.valid_o            = valid_q;
  assign mon.mismatch_o         = valid_q && (meas_q != mon.expected_divisor_i);
  assign mon.change_o           = change_q;
  assign mon.range_err_o        = range_q;
  assign mon.stuck_o            = stuck_q;
  assign mon.stuck_level_o      = stuck_q & sync_level;

endmodule

// File: tb/tb_hemaia_clock_divisor_monitor.sv
// Directed + randomized bench for hemaia_clock_divisor_monitor against an
// edge-history / period-queue reference model.
`timescale 1ns/1ps
module tb_hemaia_clock_divisor_monitor;

  localparam int W    = 4;
  localparam int SS   = 2;
  localparam int MC   = 4;
  localparam int TO   = 32;
  localparam int MAXP = 15;

  logic clk = 1'b0;
  logic rst;

  hemaia_clock_divisor_monitor_if #(.MaxDivisionWidth(W)) mon_if ();

  hemaia_clock_divisor_monitor #(
    .MaxDivisionWidth(W),
    .SyncStages(SS),
    .MatchCount(MC),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mon(mon_if)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ACQ, M_MEAS, M_LOCK, M_STUCK} mode_t;
  mode_t mode = M_IDLE;
  int    k = 0;          // posedge index
  bit    hist [8];       // sampled clk_div level per posedge (circular)
  int    origin = 0;     // edge index at which the elapsed-cycle count was 0
  int    runq[$];        // periods observed since last restart
  int    e_meas = 0;
  bit    e_valid = 0, e_change = 0, e_range = 0, e_stuck = 0;

  function automatic bit run_locked();
    if (runq.size() < MC) return 1'b0;
    for (int i = runq.size() - MC; i < runq.size(); i++)
      if (runq[i] != runq[runq.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int elapsed;
    bit seen_rise;
    k++;
    hist[k % 8] = mon_if.clk_div_i;
    seen_rise = hist[(k + 8 - SS) % 8] && !hist[(k + 7 - SS) % 8];
    elapsed   = k - origin;
    e_change  = 1'b0;
    e_range   = 1'b0;
    if (rst) begin
      for (int j = 0; j <= SS; j++) hist[(k + 8 - j) % 8] = 1'b0;
      mode = M_IDLE; e_meas = 0; e_valid = 0; e_stuck = 0;
      origin = k + 1; runq.delete();
    end else if (!mon_if.enable_i) begin
      mode = M_IDLE; e_valid = 0; e_stuck = 0; origin = k + 1;
    end else begin
      case (mode)
        M_IDLE: begin mode = M_ACQ; origin = k + 1; end
        M_ACQ: begin
          if (seen_rise) begin mode = M_MEAS; origin = k; runq.delete(); end
          else if (elapsed >= TO) begin mode = M_STUCK; e_stuck = 1; end
        end
        M_MEAS: begin
          if (seen_rise) begin
            origin = k;
            if (elapsed > MAXP) begin e_range = 1; runq.delete(); end
            else begin
              runq.push_back(elapsed);
              if (run_locked()) begin
                e_meas = elapsed; e_valid = 1; mode = M_LOCK; runq.delete();
              end
            end
          end else if (elapsed >= TO) begin mode = M_STUCK; e_stuck = 1; end
        end
        M_LOCK: begin
          if (seen_rise) begin
            origin = k;
            if (elapsed != e_meas) begin
              e_change = 1; e_valid = 0; mode = M_MEAS; runq.delete();
              if (elapsed > MAXP) e_range = 1;
              else runq.push_back(elapsed);
            end
          end else if (elapsed >= TO) begin
            mode = M_STUCK; e_valid = 0; e_stuck = 1;
          end
        end
        M_STUCK: begin
          if (seen_rise) begin
            mode = M_MEAS; e_stuck = 0; origin = k; runq.delete();
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  // ---------------- checking ----------------
  int nchk = 0, npass = 0;
  int tcyc = 0, valid_rise_cyc = 0, change_cnt = 0, range_cnt = 0;
  bit prev_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    tcyc++;
    chk("measured",    32'(mon_if.measured_divisor_o), 32'(e_meas));
    chk("valid",       32'(mon_if.valid_o),            32'(e_valid));
    chk("mismatch",    32'(mon_if.mismatch_o),
        32'(e_valid && (e_meas != int'(mon_if.expected_divisor_i))));
    chk("change",      32'(mon_if.change_o),           32'(e_change));
    chk("range_err",   32'(mon_if.range_err_o),        32'(e_range));
    chk("stuck",       32'(mon_if.stuck_o),            32'(e_stuck));
    chk("stuck_level", 32'(mon_if.stuck_level_o),
        32'(e_stuck && hist[(k + 9 - SS) % 8]));
    if (mon_if.valid_o === 1'b1 && !prev_valid) valid_rise_cyc = tcyc;
    prev_valid = (mon_if.valid_o === 1'b1);
    if (mon_if.change_o === 1'b1) change_cnt++;
    if (mon_if.range_err_o === 1'b1) range_cnt++;
  endtask

  task automatic periods(input int d, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < d; c++) begin
        mon_if.clk_div_i = (c < d / 2);
        tick();
      end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      mon_if.clk_div_i = v;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int r;
    rst = 1'b1;
    mon_if.enable_i = 1'b0;
    mon_if.clk_div_i = 1'b0;
    mon_if.expected_divisor_i = 4'd4;
    hold(0, 4);
    chk("reset_valid", 32'(mon_if.valid_o), 0);
    chk("reset_measured", 32'(mon_if.measured_divisor_o), 0);
    chk("reset_stuck", 32'(mon_if.stuck_o), 0);

    // steady divide-by-4
    rst = 1'b0;
    mon_if.enable_i = 1'b1;
    start = tcyc;
    periods(4, 7);
    chk("lock4_latency", 32'(valid_rise_cyc > start && valid_rise_cyc - start <= 5*4 + SS + 2), 1);
    chk("lock4_measured", 32'(mon_if.measured_divisor_o), 4);
    chk("lock4_mismatch", 32'(mon_if.mismatch_o), 0);

    // reprogram 4 -> 6
    change_cnt = 0;
    periods(6, 6);
    chk("chg6_pulses", 32'(change_cnt), 1);
    chk("chg6_measured", 32'(mon_if.measured_divisor_o), 6);
    chk("chg6_valid", 32'(mon_if.valid_o), 1);

    // odd divisor, software still expects 4
    periods(5, 6);
    chk("odd5_measured", 32'(mon_if.measured_divisor_o), 5);
    chk("odd5_mismatch", 32'(mon_if.mismatch_o), 1);

    // gated, then bypass, then restart at 3
    hold(0, 40);
    chk("gated_stuck", 32'(mon_if.stuck_o), 1);
    chk("gated_level", 32'(mon_if.stuck_level_o), 0);
    chk("gated_valid", 32'(mon_if.valid_o), 0);
    chk("gated_measured_held", 32'(mon_if.measured_divisor_o), 5);
    hold(1, 40);
    chk("bypass_stuck", 32'(mon_if.stuck_o), 1);
    chk("bypass_level", 32'(mon_if.stuck_level_o), 1);
    periods(3, 8);
    chk("restart3_stuck", 32'(mon_if.stuck_o), 0);
    chk("restart3_measured", 32'(mon_if.measured_divisor_o), 3);
    chk("restart3_valid", 32'(mon_if.valid_o), 1);

    // 20-cycle gap while measuring
    periods(5, 1);
    hold(1, 1);
    hold(0, 19);
    range_cnt = 0;
    periods(5, 1);
    chk("gap_range_pulse", 32'(range_cnt), 1);
    chk("gap_no_lock", 32'(mon_if.valid_o), 0);
    periods(5, 5);
    chk("gap_relock5", 32'(mon_if.measured_divisor_o), 5);

    // enable drop mid-lock
    mon_if.enable_i = 1'b0;
    hold(0, 1);
    chk("disable_valid", 32'(mon_if.valid_o), 0);
    chk("disable_measured_held", 32'(mon_if.measured_divisor_o), 5);
    periods(5, 3);
    mon_if.enable_i = 1'b1;
    periods(5, 7);
    chk("reenable_valid", 32'(mon_if.valid_o), 1);

    // reset mid-lock
    rst = 1'b1;
    hold(0, 1);
    chk("midreset_measured", 32'(mon_if.measured_divisor_o), 0);
    chk("midreset_valid", 32'(mon_if.valid_o), 0);
    rst = 1'b0;
    periods(7, 7);
    chk("postreset_measured", 32'(mon_if.measured_divisor_o), 7);

    // randomized segments
    for (int s = 0; s < 60; s++) begin
      mon_if.expected_divisor_i = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b1; hold(0, 2); rst = 1'b0;
      end else if (r == 1) begin
        mon_if.enable_i = 1'b0;
        periods($urandom_range(2, 15), $urandom_range(1, 3));
        mon_if.enable_i = 1'b1;
      end else if (r == 2) begin
        hold(0, $urandom_range(36, 45));
      end else if (r == 3) begin
        hold(1, $urandom_range(36, 45));
      end else begin
        periods($urandom_range(2, 15), $urandom_range(1, 8));
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/hemaia_clock_divisor_monitor.md
Name: hemaia_clock_divisor_monitor

Overview:
- Receive-side checker for the HeMAiA clock divider.
- Samples a divided clock as data in the fast source-clock domain, measures its period in source-clock cycles, and recovers the effective divisor.
- Reports the recovered divisor, lock, change, stuck/gated and expected-mismatch status.
- Sits in the clock/reset controller next to each divider instance, for post-reprogramming confirmation and silicon debug.

Parameters:
MaxDivisionWidth, 4, width of divisor values; legal measured range 2..2^MaxDivisionWidth-1.
SyncStages, 2, flops in input synchronizer (>=2).
MatchCount, 4, consecutive identical periods required for lock (>=1).
TimeoutCycles, 2**(MaxDivisionWidth+1), source cycles without a rising edge before stuck is declared.

Ports:
clk_i  in  1  source (undivided) clock; all logic on posedge.
rst_i  in  1  synchronous active-high reset.
enable_i  in  1  monitor enable; low forces IDLE.
clk_div_i  in  1  divided clock under test, treated as data.
expected_divisor_i  in  MaxDivisionWidth  divisor software believes is programmed.
measured_divisor_o  out  MaxDivisionWidth  last locked period in clk_i cycles.
valid_o  out  1  measured_divisor_o is locked and current.
mismatch_o  out  1  valid_o && measured_divisor_o != expected_divisor_i.
change_o  out  1  one-cycle pulse: a locked period changed.
range_err_o  out  1  one-cycle pulse: measured period > 2^MaxDivisionWidth-1.
stuck_o  out  1  no rising edge for TimeoutCycles; covers divisor 0 (gated) and bypass (divisor 1).
stuck_level_o  out  1  synchronized clk_div_i level while stuck_o=1, else 0.

Behaviour:
- Reset (rst_i=1 at posedge):
  - Synchronizer, edge flop and counters clear to 0; FSM to IDLE.
  - All outputs 0.
  - rst_i dominates enable_i and any edge.
- Synchronizer and edge detection:
  - SyncStages-flop chain, then one edge flop.
  - rise = sync_q & ~prev_q.
  - rise is asserted SyncStages+1 cycles after a clk_div_i 0->1 transition.
- Period counter:
  - Width MaxDivisionWidth+2; saturates at all-ones.
  - On a rise cycle, loads 1 and the pre-load value is the period.
  - Otherwise increments.
  - Divisor d gives period d.
- Timeout: counter >= TimeoutCycles with no rise.
- FSM states:
  - IDLE: counter held 0. enable_i=1 -> ACQUIRE.
  - ACQUIRE: first rise -> MEASURE (counter:=1, match_cnt:=0; first partial period discarded). Timeout -> STUCK.
  - MEASURE: on rise:
    - period > 2^MaxDivisionWidth-1: range_err_o pulse, match_cnt:=0.
    - else if period == candidate: match_cnt++.
    - else candidate:=period, match_cnt:=1.
    - When match_cnt reaches MatchCount: measured_divisor_o:=candidate, valid_o:=1, -> LOCKED (same cycle as the final rise's update takes effect).
    - Timeout -> STUCK.
  - LOCKED: on rise with period == measured: stay.
    - Rise with period != measured: change_o pulse, valid_o:=0, candidate:=period, match_cnt:=1 (or range_err_o and match_cnt:=0 if out of range), -> MEASURE.
    - Timeout -> STUCK, valid_o:=0.
  - STUCK: stuck_o=1, stuck_level_o follows sync_q, valid_o=0, measured_divisor_o holds last value. Rise -> MEASURE with counter:=1, match_cnt:=0, stuck_o cleared the next cycle.
- enable_i low in any state:
  - Next cycle -> IDLE.
  - valid_o, stuck_o and stuck_level_o clear; measured_divisor_o holds.
  - Pulses are suppressed.
- Simultaneous rise and timeout: rise wins.
- mismatch_o is combinational from registered measured_divisor_o/valid_o and expected_divisor_i.
- expected_divisor_i has no other effect.
- Divisor 1 and divisor 0 are indistinguishable by design: both appear as stuck.
- Odd-divisor duty skew does not affect period.

Test Plan:
- Divider d=4 steady, MatchCount=4 -> valid_o rises after 1 acquire + 4 matching periods (≤ 5*4+SyncStages+2 cycles); measured=4; mismatch_o=0 with expected=4.
- d=5 (odd, uneven duty) -> measured=5, valid_o=1; expected=4 -> mismatch_o=1.
- Locked at 4, reprogram to 6 -> change_o single pulse at first 6-period rise, valid_o=0, relock measured=6 after 4 more matching periods.
- clk_div_i held 0 (gated) then held 1 (bypass), TimeoutCycles=32 -> stuck_o=1 after 32 edge-free cycles, stuck_level_o=0 then 1, valid_o=0; restart d=3 -> stuck_o clears, lock at 3.
- Edge-free gap of 20 cycles with W=4 -> range_err_o pulse, no lock on that period.
- rst_i or enable_i deasserted mid-LOCKED -> all outputs 0 next cycle (measured held on enable drop, cleared on reset); re-enable relocks cleanly.
